// File: rtl/sdspi_wrseq.sv
// SD-SPI single-block write sequencer: CMD24, tx-data engine run, optional CMD13.
// Ports: bus side (start/sector/lgblksz/fifo -> busy/done/err/response),
//        command engine (stb/cmd/arg <- busy/done/r1), tx-data engine
//        (start/lgblksz/fifo/abort <- busy/rxvalid/response).
module sdspi_wrseq #(
  parameter int LGTIMEOUT = 24,
  parameter bit OPT_CMD13 = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_start,
  input  logic [31:0] i_sector,
  input  logic [3:0]  i_lgblksz,
  input  logic        i_fifo,
  output logic        o_busy,
  output logic        o_done,
  output logic [2:0]  o_err,
  output logic [7:0]  o_response,
  output logic        o_cmd_stb,
  output logic [5:0]  o_cmd,
  output logic [31:0] o_cmd_arg,
  input  logic        i_cmd_busy,
  input  logic        i_cmd_done,
  input  logic [7:0]  i_cmd_r1,
  output logic        o_tx_start,
  output logic [3:0]  o_tx_lgblksz,
  output logic        o_tx_fifo,
  output logic        o_tx_abort,
  input  logic        i_tx_busy,
  input  logic        i_tx_rxvalid,
  input  logic [7:0]  i_tx_response
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD24, S_R1W, S_TXS,
    S_TXW, S_CMD13, S_R1W13, S_FIN
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          sector_q, sector_d;
  logic [3:0]           lg_q, lg_d;
  logic                 fifo_q, fifo_d;
  logic [2:0]           err_q, err_d;
  logic [7:0]           resp_q, resp_d;
  logic                 go_q, go_d;
  logic                 seen_q, seen_d;
  logic [2:0]           perr_q, perr_d;
  logic [LGTIMEOUT-1:0] cnt_q, cnt_d;

  logic       cnt_max;
  logic       in_tx;
  logic [2:0] tok_dec;
  logic       ev_seen;
  logic [2:0] ev_err;

  assign cnt_max = &cnt_q;
  assign in_tx   = (state_q == S_TXS) || (state_q == S_TXW);

  always_comb begin
    unique case (i_tx_response[3:1])
      3'b010:  tok_dec = 3'd0;
      3'b101:  tok_dec = 3'd2;
      3'b110:  tok_dec = 3'd3;
      default: tok_dec = 3'd5;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sector_d = sector_q;
    lg_d     = lg_q;
    fifo_d   = fifo_q;
    err_d    = err_q;
    resp_d   = resp_q;
    go_d     = go_q;
    seen_d   = seen_q;
    perr_d   = perr_q;
    cnt_d    = cnt_q;
    // A token arriving on the same clock as busy falling still counts.
    ev_seen  = seen_q || i_tx_rxvalid;
    ev_err   = i_tx_rxvalid ? tok_dec : perr_q;
    if (in_tx && !cnt_max)
      cnt_d = cnt_q + {{(LGTIMEOUT-1){1'b0}}, 1'b1};
    unique case (state_q)
      S_IDLE: begin
        if (i_start) begin
          sector_d = i_sector;
          lg_d     = i_lgblksz;
          fifo_d   = i_fifo;
          err_d    = 3'd0;
          resp_d   = 8'd0;
          state_d  = S_CMD24;
        end
      end
      S_CMD24: begin
        if (!i_cmd_busy) state_d = S_R1W;
      end
      S_R1W: begin
        if (i_cmd_done) begin
          if (i_cmd_r1 != 8'd0) begin
            err_d   = 3'd1;
            resp_d  = i_cmd_r1;
            state_d = S_FIN;
          end else begin
            cnt_d   = '0;
            go_d    = !i_tx_busy;
            seen_d  = 1'b0;
            perr_d  = 3'd0;
            state_d = S_TXS;
          end
        end
      end
      S_TXS: begin
        if (cnt_max) begin
          err_d   = 3'd4;
          go_d    = 1'b0;
          state_d = S_FIN;
        end else if (!go_q) begin
          // Engine still busy from before: hold off start until it clears.
          go_d = !i_tx_busy;
        end else if (i_tx_busy) begin
          go_d    = 1'b0;
          state_d = S_TXW;
        end
      end
      S_TXW: begin
        if (cnt_max) begin
          err_d   = 3'd4;
          state_d = S_FIN;
        end else begin
          if (i_tx_rxvalid) begin
            resp_d = i_tx_response;
            seen_d = 1'b1;
            perr_d = tok_dec;
          end
          if (!i_tx_busy) begin
            if (!ev_seen) begin
              err_d   = 3'd5;
              state_d = S_FIN;
            end else if (ev_err != 3'd0) begin
              err_d   = ev_err;
              state_d = S_FIN;
            end else if (OPT_CMD13) begin
              state_d = S_CMD13;
            end else begin
              err_d   = 3'd0;
              state_d = S_FIN;
            end
          end
        end
      end
      S_CMD13: begin
        if (!i_cmd_busy) state_d = S_R1W13;
      end
      S_R1W13: begin
        if (i_cmd_done) begin
          if (i_cmd_r1 != 8'd0) begin
            err_d  = 3'd6;
            resp_d = i_cmd_r1;
          end else begin
            err_d  = 3'd0;
          end
          state_d = S_FIN;
        end
      end
      S_FIN: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      sector_q <= 32'd0;
      lg_q     <= 4'd0;
      fifo_q   <= 1'b0;
      err_q    <= 3'd0;
      resp_q   <= 8'd0;
      go_q     <= 1'b0;
      seen_q   <= 1'b0;
      perr_q   <= 3'd0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      sector_q <= sector_d;
      lg_q     <= lg_d;
      fifo_q   <= fifo_d;
      err_q    <= err_d;
      resp_q   <= resp_d;
      go_q     <= go_d;
      seen_q   <= seen_d;
      perr_q   <= perr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign o_done       = (state_q == S_FIN);
  assign o_err        = err_q;
  assign o_response   = resp_q;
  assign o_cmd_stb    = (state_q == S_CMD24) || (state_q == S_CMD13);
  assign o_cmd        = (state_q == S_CMD24) ? 6'd24 :
                        (state_q == S_CMD13) ? 6'd13 : 6'd0;
  assign o_cmd_arg    = (state_q == S_CMD24) ? sector_q : 32'd0;
  assign o_tx_start   = (state_q == S_TXS) && go_q && !cnt_max;
  assign o_tx_lgblksz = lg_q;
  assign o_tx_fifo    = fifo_q;
  assign o_tx_abort   = in_tx && cnt_max;

endmodule

// File: tb/tb_sdspi_wrseq.sv
// Directed bench for sdspi_wrseq with small command / tx-data engine stand-ins.
// Runs with LGTIMEOUT=6 so the timeout path completes quickly.
module tb_sdspi_wrseq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_start;
  logic [31:0] i_sector;
  logic [3:0]  i_lgblksz;
  logic        i_fifo;
  logic        o_busy, o_done;
  logic [2:0]  o_err;
  logic [7:0]  o_response;
  logic        o_cmd_stb;
  logic [5:0]  o_cmd;
  logic [31:0] o_cmd_arg;
  logic        i_cmd_busy, i_cmd_done;
  logic [7:0]  i_cmd_r1;
  logic        o_tx_start;
  logic [3:0]  o_tx_lgblksz;
  logic        o_tx_fifo, o_tx_abort;
  logic        i_tx_busy, i_tx_rxvalid;
  logic [7:0]  i_tx_response;

  int total = 0;
  int bad = 0;

  sdspi_wrseq #(.LGTIMEOUT(6), .OPT_CMD13(1'b1)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_start(i_start), .i_sector(i_sector),
    .i_lgblksz(i_lgblksz), .i_fifo(i_fifo),
    .o_busy(o_busy), .o_done(o_done),
    .o_err(o_err), .o_response(o_response),
    .o_cmd_stb(o_cmd_stb), .o_cmd(o_cmd),
    .o_cmd_arg(o_cmd_arg),
    .i_cmd_busy(i_cmd_busy), .i_cmd_done(i_cmd_done),
    .i_cmd_r1(i_cmd_r1),
    .o_tx_start(o_tx_start),
    .o_tx_lgblksz(o_tx_lgblksz),
    .o_tx_fifo(o_tx_fifo), .o_tx_abort(o_tx_abort),
    .i_tx_busy(i_tx_busy),
    .i_tx_rxvalid(i_tx_rxvalid),
    .i_tx_response(i_tx_response)
  );

  initial forever #5 clk = ~clk;

  // Passive observers of the handshakes.
  int          acc_n = 0, txs_n = 0, done_n = 0;
  logic [5:0]  l_cmd = 0, p_cmd = 0;
  logic [31:0] l_arg = 0, p_arg = 0;
  logic [3:0]  tx_lg = 0;
  logic        tx_fifo = 0, txs_prev = 0;

  always @(posedge clk) begin
    if (o_cmd_stb && !i_cmd_busy) begin
      acc_n <= acc_n + 1;
      p_cmd <= l_cmd;
      p_arg <= l_arg;
      l_cmd <= o_cmd;
      l_arg <= o_cmd_arg;
    end
    if (o_tx_start && !txs_prev) begin
      txs_n   <= txs_n + 1;
      tx_lg   <= o_tx_lgblksz;
      tx_fifo <= o_tx_fifo;
    end
    txs_prev <= o_tx_start;
    if (o_done) done_n <= done_n + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] sec,
                           input logic [3:0] lg,
                           input logic fifo);
    i_start   = 1'b1;
    i_sector  = sec;
    i_lgblksz = lg;
    i_fifo    = fifo;
    tick();
    i_start = 1'b0;
  endtask

  task automatic cmd_phase(input logic [7:0] r1, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_cmd_stb) begin ok = 1'b1; break; end
      tick();
    end
    if (ok) begin
      tick();
      tick();
      i_cmd_done = 1'b1;
      i_cmd_r1   = r1;
      tick();
      i_cmd_done = 1'b0;
      i_cmd_r1   = 8'd0;
    end
  endtask

  task automatic wait_txstart(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_tx_start) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  // mode 0: token then busy falls; 1: both together; 2: no token
  task automatic tx_phase(input int mode, input logic [7:0] tok,
                          output bit ok);
    wait_txstart(ok);
    if (ok) begin
      i_tx_busy = 1'b1;
      tick();
      tick();
      tick();
      if (mode == 0) begin
        i_tx_rxvalid = 1'b1;
        i_tx_response = tok;
        tick();
        i_tx_rxvalid = 1'b0;
        tick();
        i_tx_busy = 1'b0;
        tick();
      end else if (mode == 1) begin
        i_tx_rxvalid = 1'b1;
        i_tx_response = tok;
        i_tx_busy = 1'b0;
        tick();
        i_tx_rxvalid = 1'b0;
      end else begin
        i_tx_busy = 1'b0;
        tick();
      end
    end
  endtask

  task automatic service(input logic [7:0] r1_13, output bit seen,
                         output logic [2:0] err,
                         output logic [7:0] resp);
    bit okc;
    seen = 1'b0;
    err  = 3'd7;
    resp = 8'hxx;
    for (int i = 0; i < 40; i++) begin
      if (o_done) begin
        seen = 1'b1;
        err  = o_err;
        resp = o_response;
        tick();
        break;
      end else if (o_cmd_stb) begin
        cmd_phase(r1_13, okc);
      end else begin
        tick();
      end
    end
  endtask

  task automatic run_write(input logic [31:0] sec, input logic [3:0] lg,
                           input logic fifo, input logic [7:0] r1,
                           input int mode, input logic [7:0] tok,
                           input logic [7:0] r1_13, output bit ok,
                           output logic [2:0] err,
                           output logic [7:0] resp);
    bit okp, seen;
    ok = 1'b1;
    start_req(sec, lg, fifo);
    cmd_phase(r1, okp);
    ok &= okp;
    if (r1 == 8'd0) begin
      tx_phase(mode, tok, okp);
      ok &= okp;
    end
    service(r1_13, seen, err, resp);
    ok &= seen;
  endtask

  task automatic test_reset;
    logic [80:0] outs;
    outs = {o_busy, o_done, o_err, o_response, o_cmd_stb, o_cmd,
            o_cmd_arg, o_tx_start, o_tx_lgblksz, o_tx_fifo, o_tx_abort};
    total++;
    if (outs !== 81'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0", outs);
    end
    rst_n = 1'b1;
    tick();
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle busy=%b done=%b want 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_good_write;
    bit ok;
    logic [2:0] err;
    logic [7:0] resp;
    int a0, t0;
    a0 = acc_n;
    t0 = txs_n;
    run_write(32'h1234_5678, 4'd9, 1'b1, 8'h00, 0, 8'hE5, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd0 || resp !== 8'hE5) begin
      bad++;
      $display("FAIL good_write ok=%b err=%0d resp=%h want 1 0 e5",
               ok, err, resp);
    end
    total++;
    if (acc_n - a0 !== 2 || p_cmd !== 6'd24 || p_arg !== 32'h1234_5678
        || l_cmd !== 6'd13 || l_arg !== 32'd0) begin
      bad++;
      $display("FAIL good_cmds n=%0d c1=%0d a1=%h c2=%0d a2=%h want 2 24 12345678 13 0",
               acc_n - a0, p_cmd, p_arg, l_cmd, l_arg);
    end
    total++;
    if (txs_n - t0 !== 1 || tx_lg !== 4'd9 || tx_fifo !== 1'b1) begin
      bad++;
      $display("FAIL good_txstart n=%0d lg=%0d fifo=%b want 1 9 1",
               txs_n - t0, tx_lg, tx_fifo);
    end
  endtask

  task automatic test_r1_error;
    bit ok;
    logic [2:0] err;
    logic [7:0] resp;
    int t0;
    t0 = txs_n;
    run_write(32'h0000_0040, 4'd9, 1'b0, 8'h04, 0, 8'h00, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd1 || resp !== 8'h04
        || txs_n - t0 !== 0) begin
      bad++;
      $display("FAIL r1_error ok=%b err=%0d resp=%h txs=%0d want 1 1 04 0",
               ok, err, resp, txs_n - t0);
    end
  endtask

  task automatic test_token_errors;
    logic [7:0] toks [3] = '{8'h0B, 8'h0D, 8'h07};
    logic [2:0] exps [3] = '{3'd2, 3'd3, 3'd5};
    bit ok;
    logic [2:0] err;
    logic [7:0] resp;
    int a0;
    for (int k = 0; k < 3; k++) begin
      a0 = acc_n;
      run_write(32'h100 + k, 4'd3, 1'b0, 8'h00, 0, toks[k], 8'h00,
                ok, err, resp);
      total++;
      if (ok !== 1'b1 || err !== exps[k] || resp !== toks[k]
          || acc_n - a0 !== 1) begin
        bad++;
        $display("FAIL token_%h ok=%b err=%0d resp=%h cmds=%0d want 1 %0d %h 1",
                 toks[k], ok, err, resp, acc_n - a0, exps[k], toks[k]);
      end
    end
  endtask

  task automatic test_simultaneous;
    bit ok;
    logic [2:0] err;
    logic [7:0] resp;
    int a0;
    a0 = acc_n;
    run_write(32'h200, 4'd9, 1'b0, 8'h00, 1, 8'hE5, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd0 || resp !== 8'hE5
        || acc_n - a0 !== 2) begin
      bad++;
      $display("FAIL simul_ok ok=%b err=%0d resp=%h cmds=%0d want 1 0 e5 2",
               ok, err, resp, acc_n - a0);
    end
    run_write(32'h201, 4'd9, 1'b0, 8'h00, 1, 8'h0B, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd2 || resp !== 8'h0B) begin
      bad++;
      $display("FAIL simul_crc ok=%b err=%0d resp=%h want 1 2 0b",
               ok, err, resp);
    end
    a0 = acc_n;
    run_write(32'h202, 4'd9, 1'b0, 8'h00, 2, 8'h00, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd5 || resp !== 8'h00
        || acc_n - a0 !== 1) begin
      bad++;
      $display("FAIL dropped_token ok=%b err=%0d resp=%h cmds=%0d want 1 5 00 1",
               ok, err, resp, acc_n - a0);
    end
  endtask

  task automatic test_cmd13_error;
    bit ok;
    logic [2:0] err;
    logic [7:0] resp;
    run_write(32'h300, 4'd9, 1'b0, 8'h00, 0, 8'hE5, 8'h20,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd6 || resp !== 8'h20) begin
      bad++;
      $display("FAIL cmd13_error ok=%b err=%0d resp=%h want 1 6 20",
               ok, err, resp);
    end
  endtask

  task automatic test_tx_busy_on_entry;
    bit ok, okp, seen, early;
    logic [2:0] err;
    logic [7:0] resp;
    early = 1'b0;
    start_req(32'h400, 4'd9, 1'b0);
    i_tx_busy = 1'b1;
    cmd_phase(8'h00, ok);
    for (int i = 0; i < 4; i++) begin
      if (o_tx_start) early = 1'b1;
      tick();
    end
    total++;
    if (early !== 1'b0) begin
      bad++;
      $display("FAIL start_while_busy got=1 want=0");
    end
    i_tx_busy = 1'b0;
    tx_phase(0, 8'hE5, okp);
    ok &= okp;
    service(8'h00, seen, err, resp);
    total++;
    if ((ok & seen) !== 1'b1 || err !== 3'd0 || resp !== 8'hE5) begin
      bad++;
      $display("FAIL busy_entry_write ok=%b err=%0d resp=%h want 1 0 e5",
               ok & seen, err, resp);
    end
  endtask

  task automatic test_timeout;
    bit ok, okc;
    int n;
    n = -1;
    start_req(32'h500, 4'd9, 1'b0);
    cmd_phase(8'h00, okc);
    wait_txstart(ok);
    ok &= okc;
    i_tx_busy = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (o_tx_abort) begin n = i; break; end
    end
    total++;
    if (ok !== 1'b1 || n !== 63) begin
      bad++;
      $display("FAIL timeout_count ok=%b at=%0d want 1 63", ok, n);
    end
    tick();
    total++;
    if (o_tx_abort !== 1'b0 || o_done !== 1'b1 || o_err !== 3'd4) begin
      bad++;
      $display("FAIL timeout_done abort=%b done=%b err=%0d want 0 1 4",
               o_tx_abort, o_done, o_err);
    end
    i_tx_busy = 1'b0;
    tick();
  endtask

  task automatic test_cmd_backpressure;
    bit ok, seen, stable;
    logic [2:0] err;
    logic [7:0] resp;
    int a0;
    a0 = acc_n;
    stable = 1'b1;
    i_cmd_busy = 1'b1;
    start_req(32'hA5A5_0001, 4'd9, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (o_cmd_stb !== 1'b1 || o_cmd !== 6'd24
          || o_cmd_arg !== 32'hA5A5_0001) stable = 1'b0;
      i_start  = (i == 4);
      i_sector = 32'hDEAD_BEEF;
      tick();
    end
    i_start = 1'b0;
    total++;
    if (stable !== 1'b1) begin
      bad++;
      $display("FAIL cmd_hold got=unstable want=stable");
    end
    i_cmd_busy = 1'b0;
    cmd_phase(8'h04, ok);
    service(8'h00, seen, err, resp);
    total++;
    if ((ok & seen) !== 1'b1 || acc_n - a0 !== 1 || err !== 3'd1) begin
      bad++;
      $display("FAIL cmd_accept_once ok=%b n=%0d err=%0d want 1 1 1",
               ok & seen, acc_n - a0, err);
    end
  endtask

  task automatic test_reset_midseq;
    bit ok, okc;
    logic [80:0] outs;
    logic [2:0] err;
    logic [7:0] resp;
    int d0;
    start_req(32'h600, 4'd9, 1'b1);
    cmd_phase(8'h00, okc);
    wait_txstart(ok);
    i_tx_busy = 1'b1;
    tick();
    tick();
    d0 = done_n;
    #2 rst_n = 1'b0;
    #1;
    outs = {o_busy, o_done, o_err, o_response, o_cmd_stb, o_cmd,
            o_cmd_arg, o_tx_start, o_tx_lgblksz, o_tx_fifo, o_tx_abort};
    total++;
    if ((ok & okc) !== 1'b1 || outs !== 81'd0) begin
      bad++;
      $display("FAIL async_reset ok=%b outs=%h want 1 0", ok & okc, outs);
    end
    tick();
    i_tx_busy = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    total++;
    if (done_n - d0 !== 0) begin
      bad++;
      $display("FAIL reset_no_done got=%0d want=0", done_n - d0);
    end
    run_write(32'h601, 4'd9, 1'b0, 8'h00, 0, 8'hE5, 8'h00,
              ok, err, resp);
    total++;
    if (ok !== 1'b1 || err !== 3'd0 || resp !== 8'hE5) begin
      bad++;
      $display("FAIL after_reset ok=%b err=%0d resp=%h want 1 0 e5",
               ok, err, resp);
    end
  endtask

  task automatic test_back_to_back;
    bit ok, okc, seen;
    logic [2:0] err;
    logic [7:0] resp;
    start_req(32'h700, 4'd9, 1'b0);
    cmd_phase(8'h04, okc);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (o_done) begin ok = 1'b1; break; end
      tick();
    end
    i_start  = 1'b1;
    i_sector = 32'h701;
    tick();
    total++;
    if ((ok & okc) !== 1'b1 || o_busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b_ignored ok=%b busy=%b want 1 0", ok & okc, o_busy);
    end
    tick();
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_cmd !== 6'd24 || o_cmd_arg !== 32'h701) begin
      bad++;
      $display("FAIL b2b_accept busy=%b cmd=%0d arg=%h want 1 24 701",
               o_busy, o_cmd, o_cmd_arg);
    end
    cmd_phase(8'h08, okc);
    service(8'h00, seen, err, resp);
    total++;
    if ((okc & seen) !== 1'b1 || err !== 3'd1 || resp !== 8'h08) begin
      bad++;
      $display("FAIL b2b_second ok=%b err=%0d resp=%h want 1 1 08",
               okc & seen, err, resp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    i_start = 1'b0;
    i_sector = 32'd0;
    i_lgblksz = 4'd0;
    i_fifo = 1'b0;
    i_cmd_busy = 1'b0;
    i_cmd_done = 1'b0;
    i_cmd_r1 = 8'd0;
    i_tx_busy = 1'b0;
    i_tx_rxvalid = 1'b0;
    i_tx_response = 8'd0;
    tick();
    tick();
    test_reset();
    test_good_write();
    test_r1_error();
    test_token_errors();
    test_simultaneous();
    test_cmd13_error();
    test_tx_busy_on_entry();
    test_timeout();
    test_cmd_backpressure();
    test_reset_midseq();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
